// File: rtl/sprite_blitter_pkg.sv
// Shared types for the sprite blitter: FSM encoding, colour type and default colour key.
package sprite_blitter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef logic [2:0] color_t;

    localparam color_t TRANSPARENT_DEFAULT = 3'b000;

endpackage

// File: rtl/sprite_blitter_pipe_delay.sv
// Fixed-depth shift register that keeps screen coordinates and flags aligned with ROM read data.
module pipe_delay #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= din_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign dout_o = stage_q[DEPTH-1];

endmodule

// File: rtl/sprite_blitter.sv
// Raster-scans a sprite ROM and emits one VGA plot strobe per visible pixel,
// with run-time origin, horizontal mirroring, colour-key transparency and screen clipping.
module sprite_blitter
    import sprite_blitter_pkg::*;
#(
    parameter int     SCREEN_W       = 160,
    parameter int     SCREEN_H       = 120,
    parameter int     WIDTH_X        = 8,
    parameter int     WIDTH_Y        = 7,
    parameter int     SPRITE_W       = 10,
    parameter int     SPRITE_H       = 6,
    parameter int     SW_X           = 4,
    parameter int     SW_Y           = 3,
    parameter int     MEM_LATENCY    = 1,
    parameter int     TRANSPARENT_EN = 1,
    parameter color_t TRANSPARENT    = TRANSPARENT_DEFAULT
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic [WIDTH_X-1:0] org_x,
    input  logic [WIDTH_Y-1:0] org_y,
    input  logic               mirror,
    output logic [SW_X-1:0]    rom_x,
    output logic [SW_Y-1:0]    rom_y,
    input  logic [2:0]         rom_color,
    output logic [WIDTH_X-1:0] vga_x,
    output logic [WIDTH_Y-1:0] vga_y,
    output logic [2:0]         vga_color,
    output logic               vga_plot,
    output logic               busy,
    output logic               done
);

    localparam int XW = WIDTH_X + 1;
    localparam int YW = WIDTH_Y + 1;
    localparam int PW = WIDTH_X + WIDTH_Y + 2;
    localparam logic [SW_X-1:0] COL_LAST   = SW_X'(SPRITE_W - 1);
    localparam logic [SW_Y-1:0] ROW_LAST   = SW_Y'(SPRITE_H - 1);
    localparam logic [1:0]      DRAIN_LAST = 2'(MEM_LATENCY);

    function automatic logic is_transparent(input color_t c);
        return (TRANSPARENT_EN != 0) && (c == TRANSPARENT);
    endfunction

    state_t             state_q, state_d;
    logic [SW_X-1:0]    col_q, col_d;
    logic [SW_Y-1:0]    row_q, row_d;
    logic [WIDTH_X-1:0] org_x_q, org_x_d;
    logic [WIDTH_Y-1:0] org_y_q, org_y_d;
    logic               mirror_q, mirror_d;
    logic [1:0]         drain_q, drain_d;

    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        row_d    = row_q;
        org_x_d  = org_x_q;
        org_y_d  = org_y_q;
        mirror_d = mirror_q;
        drain_d  = drain_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_SCAN;
                    col_d    = '0;
                    row_d    = '0;
                    org_x_d  = org_x;
                    org_y_d  = org_y;
                    mirror_d = mirror;
                end
            end
            ST_SCAN: begin
                if (col_q == COL_LAST) begin
                    col_d = '0;
                    if (row_q == ROW_LAST) begin
                        row_d   = '0;
                        drain_d = '0;
                        state_d = ST_DRAIN;
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
            // Hold for the ROM latency plus the registered output stage.
            ST_DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    drain_d = drain_q + 2'd1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            col_q    <= '0;
            row_q    <= '0;
            org_x_q  <= '0;
            org_y_q  <= '0;
            mirror_q <= 1'b0;
            drain_q  <= '0;
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            row_q    <= row_d;
            org_x_q  <= org_x_d;
            org_y_q  <= org_y_d;
            mirror_q <= mirror_d;
            drain_q  <= drain_d;
        end
    end

    assign busy  = (state_q == ST_SCAN) || (state_q == ST_DRAIN);
    assign done  = (state_q == ST_DONE);
    assign rom_y = row_q;
    assign rom_x = mirror_q ? (COL_LAST - col_q) : col_q;

    // Screen position tracks col, not rom_x, so mirroring only changes which texel lands there.
    logic [XW-1:0] sx;
    logic [YW-1:0] sy;
    logic          inb;
    logic [PW-1:0] pipe_in, pipe_out;

    assign sx      = {1'b0, org_x_q} + XW'(col_q);
    assign sy      = {1'b0, org_y_q} + YW'(row_q);
    assign inb     = (sx < XW'(SCREEN_W)) && (sy < YW'(SCREEN_H));
    assign pipe_in = {sx[WIDTH_X-1:0], sy[WIDTH_Y-1:0], inb, (state_q == ST_SCAN)};

    pipe_delay #(
        .WIDTH(PW),
        .DEPTH(MEM_LATENCY)
    ) u_delay (
        .clk   (clk),
        .resetn(resetn),
        .din_i (pipe_in),
        .dout_o(pipe_out)
    );

    logic [WIDTH_X-1:0] dl_x;
    logic [WIDTH_Y-1:0] dl_y;
    logic               dl_inb, dl_vld;

    assign {dl_x, dl_y, dl_inb, dl_vld} = pipe_out;

    logic               vga_plot_q, vga_plot_d;
    logic [WIDTH_X-1:0] vga_x_q;
    logic [WIDTH_Y-1:0] vga_y_q;
    logic [2:0]         vga_color_q;

    assign vga_plot_d = dl_vld && dl_inb && !is_transparent(rom_color);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            vga_plot_q  <= 1'b0;
            vga_x_q     <= '0;
            vga_y_q     <= '0;
            vga_color_q <= '0;
        end else begin
            vga_plot_q  <= vga_plot_d;
            vga_x_q     <= dl_x;
            vga_y_q     <= dl_y;
            vga_color_q <= rom_color;
        end
    end

    assign vga_plot  = vga_plot_q;
    assign vga_x     = vga_x_q;
    assign vga_y     = vga_y_q;
    assign vga_color = vga_color_q;

endmodule

// File: tb/tb_sprite_blitter.sv
// Directed bench for sprite_blitter: two instances (colour key on / off) fed by a registered ROM model.
module tb_sprite_blitter;
    import sprite_blitter_pkg::*;

    logic       clk = 1'b0;
    logic       resetn, start, mirror;
    logic [7:0] org_x;
    logic [6:0] org_y;

    logic [3:0] rx0, rx1;
    logic [2:0] ry0, ry1;
    logic [2:0] rc0, rc1;
    logic [7:0] vga_x, vga_x_nt;
    logic [6:0] vga_y, vga_y_nt;
    logic [2:0] vga_color, vga_color_nt;
    logic       vga_plot, vga_plot_nt, busy, busy_nt, done, done_nt;

    logic [2:0] rom [128];

    int total = 0;
    int bad   = 0;

    int n0, n1, done_cnt, done_cyc, done_cnt1, done_cyc1, first_plot, late_plots;
    int busy1, busy62, busy63, busy1_nt, nt_fx, nt_fc, rst_state_ok;
    logic [27:0] rst_snap;
    int px[64], py[64], pc[64];

    always #5 clk = ~clk;

    sprite_blitter #(.TRANSPARENT_EN(1)) u_dut (
        .clk(clk), .resetn(resetn), .start(start), .org_x(org_x), .org_y(org_y), .mirror(mirror),
        .rom_x(rx0), .rom_y(ry0), .rom_color(rc0),
        .vga_x(vga_x), .vga_y(vga_y), .vga_color(vga_color), .vga_plot(vga_plot),
        .busy(busy), .done(done)
    );

    sprite_blitter #(.TRANSPARENT_EN(0)) u_dut_nt (
        .clk(clk), .resetn(resetn), .start(start), .org_x(org_x), .org_y(org_y), .mirror(mirror),
        .rom_x(rx1), .rom_y(ry1), .rom_color(rc1),
        .vga_x(vga_x_nt), .vga_y(vga_y_nt), .vga_color(vga_color_nt), .vga_plot(vga_plot_nt),
        .busy(busy_nt), .done(done_nt)
    );

    always_ff @(posedge clk) begin
        rc0 <= rom[{ry0, rx0}];
        rc1 <= rom[{ry1, rx1}];
    end

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [27:0] snap();
        return {vga_plot, done, busy, vga_x, vga_y, vga_color, rx0, ry0};
    endfunction

    // Fill every sprite texel with a non-key colour: (r*10+c)%7 + 1.
    task automatic rom_plain();
        for (int i = 0; i < 128; i++) rom[i] = 3'd0;
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 10; c++)
                rom[r*16 + c] = 3'(((r*10 + c) % 7) + 1);
    endtask

    task automatic run_blit(input logic [7:0] ox, input logic [6:0] oy, input logic mir,
                            input int restart_at, input int reset_at);
        n0 = 0; n1 = 0; done_cnt = 0; done_cyc = -1; done_cnt1 = 0; done_cyc1 = -1;
        first_plot = -1; late_plots = 0; nt_fx = -1; nt_fc = -1;
        busy1 = -1; busy62 = -1; busy63 = -1; busy1_nt = -1;
        rst_snap = '1; rst_state_ok = 0;
        @(negedge clk);
        org_x = ox; org_y = oy; mirror = mir; start = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk);
            if (k == 1)  begin busy1 = int'(busy); busy1_nt = int'(busy_nt); end
            if (k == 62) busy62 = int'(busy);
            if (k == 63) busy63 = int'(busy);
            if (vga_plot) begin
                if (n0 < 64) begin
                    px[n0] = int'(vga_x); py[n0] = int'(vga_y); pc[n0] = int'(vga_color);
                end
                if (first_plot < 0) first_plot = k;
                if (reset_at > 0 && k > reset_at) late_plots++;
                n0++;
            end
            if (vga_plot_nt) begin
                if (n1 == 0) begin nt_fx = int'(vga_x_nt) + 256 * int'(vga_y_nt); nt_fc = int'(vga_color_nt); end
                n1++;
            end
            if (done) begin done_cnt++; if (done_cyc < 0) done_cyc = k; end
            if (done_nt) begin done_cnt1++; if (done_cyc1 < 0) done_cyc1 = k; end
            if (reset_at > 0 && k == reset_at + 1) begin
                rst_snap = snap();
                rst_state_ok = (u_dut.state_q == ST_IDLE) ? 1 : 0;
            end
            start  = (k == restart_at) ? 1'b1 : 1'b0;
            resetn = (k == reset_at) ? 1'b0 : 1'b1;
        end
    endtask

    initial begin
        int errs;
        resetn = 1'b0; start = 1'b0; mirror = 1'b0; org_x = '0; org_y = '0;
        rom_plain();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", int'(snap()), 0);
        resetn = 1'b1;

        // Plain blit at the origin.
        run_blit(8'd0, 7'd0, 1'b0, 0, 0);
        check("t1_plots", n0, 60);
        check("t1_plots_nt", n1, 60);
        check("t1_done_cycle", done_cyc, 63);
        check("t1_done_count", done_cnt, 1);
        check("t1_done_cycle_nt", done_cyc1, 63);
        check("t1_first_plot_cycle", first_plot, 3);
        check("t1_busy_c1", busy1, 1);
        check("t1_busy_nt_c1", busy1_nt, 1);
        check("t1_busy_c62", busy62, 1);
        check("t1_busy_c63", busy63, 0);
        errs = 0;
        for (int i = 0; i < 60; i++)
            if (px[i] != i % 10 || py[i] != i / 10 || pc[i] != (i % 7) + 1) errs++;
        check("t1_raster_order", errs, 0);

        // Clipping at the bottom-right corner.
        run_blit(8'd155, 7'd118, 1'b0, 0, 0);
        check("t2_plots", n0, 10);
        check("t2_done_cycle", done_cyc, 63);
        check("t2_first_x", px[0], 155);
        check("t2_first_y", py[0], 118);
        errs = 0;
        for (int i = 0; i < 10; i++)
            if (px[i] < 155 || px[i] > 159 || py[i] < 118 || py[i] > 119) errs++;
        check("t2_in_bounds", errs, 0);

        // Mirroring: row 0 = 1..7,1,2,3.
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 10; c++)
                rom[r*16 + c] = (r == 0) ? 3'((c % 7) + 1) : 3'd4;
        run_blit(8'd0, 7'd0, 1'b1, 0, 0);
        check("t3_plots", n0, 60);
        check("t3_col0_color", pc[0], 3);
        check("t3_col9_x", px[9], 9);
        check("t3_col9_color", pc[9], 1);

        // Even columns carry the colour key.
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 10; c++)
                rom[r*16 + c] = (c % 2 == 0) ? 3'd0 : 3'd5;
        run_blit(8'd0, 7'd0, 1'b0, 0, 0);
        check("t4_plots_key_on", n0, 30);
        check("t4_plots_key_off", n1, 60);
        check("t4_first_x_key_on", px[0], 1);
        check("t4_first_pos_key_off", nt_fx, 0);
        check("t4_first_color_key_off", nt_fc, 0);

        // Second start in cycle 10 is ignored.
        rom_plain();
        run_blit(8'd0, 7'd0, 1'b0, 10, 0);
        check("t5_done_count", done_cnt, 1);
        check("t5_done_cycle", done_cyc, 63);
        check("t5_plots", n0, 60);

        // Reset asserted in cycle 20 abandons the blit.
        run_blit(8'd0, 7'd0, 1'b0, 0, 20);
        check("t6_outputs_after_reset", int'(rst_snap), 0);
        check("t6_state_idle", rst_state_ok, 1);
        check("t6_late_plots", late_plots, 0);
        check("t6_done_count", done_cnt, 0);
        run_blit(8'd0, 7'd0, 1'b0, 0, 0);
        check("t6_restart_done_cycle", done_cyc, 63);
        check("t6_restart_plots", n0, 60);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
